flash_audio_sequencer: RTL
==========================

FLASH_AUDIO_SEQUENCER -- requirements
Module: flash_audio_sequencer

Interface
REQ-001 Parameter LAST_ADDR, default 23'h7FFFF, sets the last word address of the song region.
REQ-002 CLK_50M  input  1  system clock; every flop SHALL be clocked on its rising edge.
REQ-003 reset  input  1  reset, synchronous and active-high.
REQ-004 play  input  1  level: 1 = run, 0 = pause; already synchronised to CLK_50M.
REQ-005 reverse  input  1  level: 1 = backward, 0 = forward; already synchronised.
REQ-006 restart  input  1  one-cycle pulse requesting a jump to the start of the song.
REQ-007 sample_tick  input  1  one-cycle strobe at the audio sample rate.
REQ-008 flash_mem_read  output  1  flash read request.
REQ-009 flash_mem_address  output  23  flash word address.
REQ-010 flash_mem_byteenable  output  4  SHALL be constant 4'b1111.
REQ-011 flash_mem_waitrequest  input  1  flash stall; a request is accepted in a cycle where read=1 and waitrequest=0.
REQ-012 flash_mem_readdata  input  32  read word.
REQ-013 flash_mem_readdatavalid  input  1  readdata is valid this cycle.
REQ-014 audio_data  output  16  current signed sample.
REQ-015 audio_valid  output  1  one-cycle pulse when audio_data updates.

Function
REQ-016 The FSM SHALL have the states IDLE, REQ, WAIT_DATA, HALF1, HALF2 and ADVANCE.
REQ-017 IDLE -> REQ when play=1; otherwise it SHALL stay in IDLE.
REQ-018 REQ: read=1 and the address SHALL be held stable until waitrequest=0, then -> WAIT_DATA with read=0 the next cycle.
REQ-019 WAIT_DATA: on readdatavalid the word SHALL be latched, the latched reverse SHALL fix the half order, and the FSM -> HALF1.
REQ-020 Half order: forward = [15:0] then [31:16]; reverse = [31:16] then [15:0].
REQ-021 HALF1/HALF2: on sample_tick with play=1, audio_data SHALL load the selected half and audio_valid SHALL pulse 1 in the next cycle (1-cycle latency).
REQ-022 The transition is HALF1 -> HALF2 -> ADVANCE.
REQ-023 sample_tick with play=0 SHALL be ignored; audio_data holds and no audio_valid is produced.
REQ-024 ADVANCE (1 cycle): with reverse=0, address+1, and LAST_ADDR wraps to 0.
REQ-025 ADVANCE (1 cycle): with reverse=1, address-1, and 0 wraps to LAST_ADDR; the FSM then -> IDLE.
REQ-026 A change of reverse mid-word SHALL take effect at the next ADVANCE and the next word latch only.
REQ-027 play=0 during REQ/WAIT_DATA SHALL NOT abort the read; the word is latched and playback pauses in HALF1.
REQ-028 restart SHALL set a restart_pending flag.
REQ-029 In IDLE, HALF1, HALF2 or ADVANCE, a pending restart SHALL set address to 0 (reverse=0) or LAST_ADDR (reverse=1), clear the flag, and go to IDLE.
REQ-030 When restart is applied, the buffered word SHALL be discarded.
REQ-031 In REQ/WAIT_DATA, a pending restart SHALL wait for readdatavalid, discard that word, apply the reload, and go to IDLE.
REQ-032 restart and sample_tick in the same cycle: restart wins and no audio_valid is produced.
REQ-033 audio_valid SHALL never be asserted in two consecutive cycles.
REQ-034 Exactly one flash read SHALL be outstanding at most.
REQ-035 readdatavalid outside WAIT_DATA SHALL be ignored.

Reset
REQ-036 On reset=1 at a clock edge: state=IDLE, flash_mem_address=0, flash_mem_read=0.
REQ-037 On reset=1 at a clock edge: audio_data=16'h0000, audio_valid=0, restart_pending=0, latched word=0.
REQ-038 reset SHALL override every other input, including mid-read; a readdatavalid arriving after reset SHALL be ignored.

Structure
REQ-039 The state enum, LAST_ADDR default and byteenable constant SHALL live in package flash_audio_pkg.
REQ-040 A single sub-module, sample_half_select, SHALL hold the 32-bit word register and the half-order mux.
REQ-041 All outputs SHALL be registered.

Verification
REQ-042 Forward: after reset with play=1, reverse=0, waitrequest low for 2 cycles, word 32'hBBBB_AAAA, and two ticks -> audio_data is 16'hAAAA then 16'hBBBB, then address=1.
REQ-043 Reverse wrap: with address=0, reverse=1 and word 32'h2222_1111 -> outputs are 16'h2222 then 16'h1111, and the next address is 23'h7FFFF.
REQ-044 Forward wrap: with address=23'h7FFFF, reverse=0 and two ticks -> the next read is at address 0.
REQ-045 Pause: play=0 in HALF2 with 5 ticks -> no audio_valid and audio_data unchanged; play=1 with one tick -> the second half is output.
REQ-046 Restart mid-read: restart while in WAIT_DATA, with reverse=1, then readdatavalid 3 cycles later -> no audio_valid, and the next read is at 23'h7FFFF.
REQ-047 Reset mid-read: reset during WAIT_DATA, followed by readdatavalid -> outputs stay at reset values and the next read is at address 0.

Source files
------------

// File: rtl/flash_audio_pkg.sv
// Shared types and constants for the flash audio sequencer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package flash_audio_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_DATA,
    HALF1,
    HALF2,
    ADVANCE
  } seq_state_t;

  localparam logic [22:0] LAST_ADDR_DEFAULT = 23'h7FFFF;
  localparam logic [3:0]  BYTEENABLE_ALL    = 4'b1111;

  // Next word address in the song region; both directions wrap at the region ends.
  function automatic logic [22:0] step_addr(input logic [22:0] addr,
                                            input logic        rev,
                                            input logic [22:0] last);
    logic [22:0] nxt;
    if (rev) nxt = (addr == 23'd0) ? last : addr - 23'd1;
    else     nxt = (addr == last)  ? 23'd0 : addr + 23'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/sample_half_select.sv
// Holds one fetched 32-bit flash word and selects which 16-bit half plays next.
// Latency: word captured on load; half_data is combinational from the stored word.
// Backpressure: none; load/clear are single-cycle strobes from the sequencer.
module sample_half_select (
  input  logic        CLK_50M,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] word_in,
  input  logic        word_rev_in,
  input  logic        half_sel,
  output logic [15:0] half_data
);

  logic [31:0] word_q;
  logic        rev_q;

  // Capture the word with the direction that was active when it arrived, so a
  // later direction change cannot reorder the halves of a word already in flight.
  always_ff @(posedge CLK_50M) begin
    if (reset || clear) begin
      word_q <= 32'h0;
      rev_q  <= 1'b0;
    end else if (load) begin
      word_q <= word_in;
      rev_q  <= word_rev_in;
    end
  end

  // Forward plays low half first; reverse plays high half first.
  always_comb begin
    half_data = word_q[15:0];
    if (half_sel ^ rev_q) half_data = word_q[31:16];
  end

endmodule

// File: rtl/flash_audio_sequencer.sv
// Streams 16-bit audio samples from flash, one 32-bit word at a time, forward or reverse.
// Latency: sample appears on audio_data/audio_valid one cycle after the accepted sample_tick.
// Backpressure: holds read/address while waitrequest=1; ticks are dropped while paused.
module flash_audio_sequencer
  import flash_audio_pkg::*;
#(
  parameter logic [22:0] LAST_ADDR = LAST_ADDR_DEFAULT
) (
  input  logic        CLK_50M,
  input  logic        reset,
  input  logic        play,
  input  logic        reverse,
  input  logic        restart,
  input  logic        sample_tick,
  output logic        flash_mem_read,
  output logic [22:0] flash_mem_address,
  output logic [3:0]  flash_mem_byteenable,
  input  logic        flash_mem_waitrequest,
  input  logic [31:0] flash_mem_readdata,
  input  logic        flash_mem_readdatavalid,
  output logic [15:0] audio_data,
  output logic        audio_valid
);

  seq_state_t  state_q, state_nxt;
  logic [22:0] addr_q;
  logic        read_q;
  logic [15:0] audio_data_q;
  logic        audio_valid_q;
  logic        restart_pending_q;

  logic        restart_now;
  logic        fire;
  logic        reload;
  logic        latch_word;
  logic        emit;
  logic        half_sel;
  logic        advance;
  logic [15:0] half_data;

  // A restart arriving this very cycle counts as pending so it beats a same-cycle tick.
  assign restart_now = restart_pending_q | restart;
  // Refuse a tick right after a pulse so audio_valid never stays high two cycles.
  assign fire        = sample_tick & play & ~audio_valid_q;

  // State register.
  always_ff @(posedge CLK_50M) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_nxt;
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_nxt  = state_q;
    reload     = 1'b0;
    latch_word = 1'b0;
    emit       = 1'b0;
    half_sel   = 1'b0;
    advance    = 1'b0;
    case (state_q)
      IDLE: begin
        if (restart_now) reload = 1'b1;
        else if (play)   state_nxt = REQ;
      end
      REQ: begin
        // A pending restart cannot cancel an issued request; it is handled at data return.
        if (read_q && !flash_mem_waitrequest) state_nxt = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (flash_mem_readdatavalid) begin
          if (restart_now) begin
            reload    = 1'b1;
            state_nxt = IDLE;
          end else begin
            latch_word = 1'b1;
            state_nxt  = HALF1;
          end
        end
      end
      HALF1: begin
        if (restart_now) begin
          reload    = 1'b1;
          state_nxt = IDLE;
        end else if (fire) begin
          emit      = 1'b1;
          state_nxt = HALF2;
        end
      end
      HALF2: begin
        half_sel = 1'b1;
        if (restart_now) begin
          reload    = 1'b1;
          state_nxt = IDLE;
        end else if (fire) begin
          emit      = 1'b1;
          state_nxt = ADVANCE;
        end
      end
      ADVANCE: begin
        if (restart_now) reload  = 1'b1;
        else             advance = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs, address pointer and restart bookkeeping.
  always_ff @(posedge CLK_50M) begin
    if (reset) begin
      addr_q            <= 23'h0;
      read_q            <= 1'b0;
      audio_data_q      <= 16'h0000;
      audio_valid_q     <= 1'b0;
      restart_pending_q <= 1'b0;
    end else begin
      read_q            <= (state_nxt == REQ);
      audio_valid_q     <= emit;
      restart_pending_q <= reload ? 1'b0 : restart_pending_q | restart;
      if (emit) audio_data_q <= half_data;
      if (reload)       addr_q <= reverse ? LAST_ADDR : 23'h0;
      else if (advance) addr_q <= step_addr(addr_q, reverse, LAST_ADDR);
    end
  end

  sample_half_select u_half_select (
    .CLK_50M     (CLK_50M),
    .reset       (reset),
    .load        (latch_word),
    .clear       (reload),
    .word_in     (flash_mem_readdata),
    .word_rev_in (reverse),
    .half_sel    (half_sel),
    .half_data   (half_data)
  );

  assign flash_mem_read       = read_q;
  assign flash_mem_address    = addr_q;
  assign flash_mem_byteenable = BYTEENABLE_ALL;
  assign audio_data           = audio_data_q;
  assign audio_valid          = audio_valid_q;

endmodule
